shift_add_mul8: RTL and testbench

Sequential 8x8 unsigned shift-and-add multiplier built around the team's 8-bit ripple-carry adder. It sits directly downstream of the adder stage: it feeds the adder a partial product and the multiplicand each cycle, and consumes its sum and carry-out. It produces a 16-bit product after 8 iterations, using a start/busy/done handshake.

---
 rtl/shift_add_mul8_pkg.sv | 14 +
 rtl/shift_add_mul8_fad8.sv | 25 ++
 rtl/shift_add_mul8.sv | 89 ++++++++
 tb/tb_shift_add_mul8.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mul8_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM encodings and iteration constants.
package shift_add_mul8_pkg;

    localparam int N_BITS = 8;
    localparam logic [3:0] CNT_LAST = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/shift_add_mul8_fad8.sv
// fad8: 8-bit ripple-carry adder built from a chain of full-adder cells.
// carry[0] is the carry-out of the MSB; carry[7:1] are tied to zero.
module fad8
    import shift_add_mul8_pkg::*;
(
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic [N_BITS-1:0] s,
    output logic [N_BITS-1:0] carry
);

    logic [N_BITS:0] c;

    assign c[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N_BITS; gi++) begin : g_fa
            assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign carry = {{(N_BITS-1){1'b0}}, c[N_BITS]};

endmodule

// File: rtl/shift_add_mul8.sv
// Sequential 8x8 unsigned multiplier: one shift-and-add step per cycle
// through a single ripple adder, start/busy/done handshake, 16-bit product.
module shift_add_mul8
    import shift_add_mul8_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    state_t      state_reg, state_next;
    logic [7:0]  m_reg, m_next;
    logic [15:0] p_reg, p_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [15:0] product_reg, product_next;

    logic [7:0]  add_s;
    logic [7:0]  add_carry;

    fad8 u_fad8 (
        .a     (p_reg[15:8]),
        .b     (m_reg),
        .s     (add_s),
        .carry (add_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            m_reg       <= '0;
            p_reg       <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            m_reg       <= m_next;
            p_reg       <= p_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        m_next       = m_reg;
        p_next       = p_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    m_next     = a;
                    p_next     = {8'h00, b};
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                // The adder carry becomes bit 15 so full-scale sums are never lost.
                if (p_reg[0])
                    p_next = {add_carry[0], add_s, p_reg[7:1]};
                else
                    p_next = {1'b0, p_reg[15:8], p_reg[7:1]};
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == CNT_LAST) begin
                    state_next   = DONE;
                    product_next = p_next;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign product = product_reg;

endmodule

// File: tb/tb_shift_add_mul8.sv
// Self-checking bench for shift_add_mul8: directed scenarios plus random
// operands checked against plain a*b arithmetic and a 9-edge latency rule.
module tb_shift_add_mul8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_add_mul8 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // Drives one operation from an idle negedge and reports what was observed.
    // Operands are scrambled right after the start edge to prove they were captured.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv,
                          output logic [15:0] res, output int lat,
                          output int busy_gaps, output logic done_busy,
                          output logic post_done, output logic post_busy);
        logic got;
        a = ta; b = tbv; start = 1'b1;
        lat = 0; busy_gaps = 0; got = 1'b0; res = 16'hxxxx; done_busy = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            a = 8'($urandom); b = 8'($urandom);
            lat++;
            if (done) begin
                got = 1'b1;
                res = product;
                done_busy = busy;
                break;
            end
            if (!busy) busy_gaps++;
        end
        if (!got) lat = -1;
        @(negedge clk);
        post_done = done;
        post_busy = busy;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (product !== 16'h0000) begin n_bad++; $display("FAIL reset_product: got %h want 0000", product); end
        // rst and start on the same edge: reset must win
        start = 1'b1; a = 8'd5; b = 8'd5;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_start_busy: got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_start_idle: got %b want 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_directed;
        logic [7:0]  ta [5] = '{8'd13, 8'd255, 8'd0,   8'd1,   8'd255};
        logic [7:0]  tb2[5] = '{8'd11, 8'd255, 8'd200, 8'd255, 8'd1};
        logic [15:0] res;
        logic [15:0] exp;
        int lat, gaps;
        logic db, pd, pb;
        for (int i = 0; i < 5; i++) begin
            exp = 16'(ta[i]) * 16'(tb2[i]);
            run_op(ta[i], tb2[i], res, lat, gaps, db, pd, pb);
            $display("directed %0d*%0d -> %h (lat %0d)", ta[i], tb2[i], res, lat);
            n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL dir_product[%0d]: got %h want %h", i, res, exp); end
            n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL dir_latency[%0d]: got %0d want 9", i, lat); end
            n_cmp++; if (gaps != 0) begin n_bad++; $display("FAIL dir_busy[%0d]: got %0d low cycles want 0", i, gaps); end
            n_cmp++; if (db !== 1'b0) begin n_bad++; $display("FAIL dir_busy_in_done[%0d]: got %b want 0", i, db); end
            n_cmp++; if (pd !== 1'b0) begin n_bad++; $display("FAIL dir_done_width[%0d]: got %b want 0", i, pd); end
            n_cmp++; if (product !== exp) begin n_bad++; $display("FAIL dir_hold[%0d]: got %h want %h", i, product, exp); end
        end
    endtask

    task automatic test_ignored_start;
        int k;
        logic got;
        a = 8'd3; b = 8'd5; start = 1'b1;
        k = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
            if (k == 4) begin start = 1'b1; a = 8'd9; b = 8'd9; end
            if (k == 5) start = 1'b0;
            if (done) begin got = 1'b1; break; end
        end
        $display("ignored_start first -> %h (lat %0d)", product, k);
        n_cmp++; if (!got || k != 9) begin n_bad++; $display("FAIL ign_latency: got %0d want 9", got ? k : -1); end
        n_cmp++; if (product !== 16'h000F) begin n_bad++; $display("FAIL ign_first: got %h want 000f", product); end
        // start held through the done cycle must be taken once the block is idle
        start = 1'b1; a = 8'd9; b = 8'd9;
        got = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (busy) start = 1'b0;
            if (done) begin got = 1'b1; break; end
        end
        start = 1'b0;
        $display("ignored_start second -> %h", product);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL ign_second_timeout: got no done want done"); end
        n_cmp++; if (product !== 16'h0051) begin n_bad++; $display("FAIL ign_second: got %h want 0051", product); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int done_cnt;
        logic [15:0] res;
        int lat, gaps;
        logic db, pd, pb;
        a = 8'd200; b = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done: got %b want 0", done); end
        n_cmp++; if (product !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_product: got %h want 0000", product); end
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL mid_rst_quiet: got %0d active cycles want 0", done_cnt); end
        run_op(8'd2, 8'd3, res, lat, gaps, db, pd, pb);
        $display("after reset 2*3 -> %h", res);
        n_cmp++; if (res !== 16'h0006) begin n_bad++; $display("FAIL mid_rst_next: got %h want 0006", res); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  ta, tbv;
        logic [15:0] res, exp, prev;
        int lat, gaps;
        logic db, pd, pb;
        prev = product;
        for (int i = 0; i < 1000; i++) begin
            ta = 8'($urandom); tbv = 8'($urandom);
            exp = 16'(ta) * 16'(tbv);
            n_cmp++; if (product !== prev) begin n_bad++; $display("FAIL rnd_hold[%0d]: got %h want %h", i, product, prev); end
            run_op(ta, tbv, res, lat, gaps, db, pd, pb);
            $display("rnd %0d: %0d*%0d -> %h lat %0d", i, ta, tbv, res, lat);
            n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL rnd_product[%0d]: got %h want %h", i, res, exp); end
            n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want 9", i, lat); end
            n_cmp++; if (gaps != 0 || db !== 1'b0) begin n_bad++; $display("FAIL rnd_busy[%0d]: got gaps %0d busy_in_done %b want 0/0", i, gaps, db); end
            n_cmp++; if (pd !== 1'b0 || pb !== 1'b0) begin n_bad++; $display("FAIL rnd_done_width[%0d]: got done %b busy %b want 0/0", i, pd, pb); end
            prev = exp;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
